req_ack_requester: RTL and testbench
====================================

REQ_ACK_REQUESTER -- requirements
Module: req_ack_requester

Interface
REQ-001 Parameter ACK_LAT, default 4: fixed number of cycles from the req cycle to the expected ack cycle.
REQ-002 Parameter REQ_GAP, default 8: minimum distance in cycles between two req pulses; legal only when REQ_GAP > ACK_LAT+1.
REQ-003 Parameter CNT_W, default 8: width of req_count and ack_count.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to issue one req pulse.
REQ-007 ack  input  1  acknowledge from the downstream responder.
REQ-008 clr_err  input  1  synchronous clear of err.
REQ-009 req  output  1  registered one-cycle request pulse to the responder.
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 done  output  1  one-cycle pulse closing each transaction.
REQ-012 ack_ok  output  1  valid with done; 1 = ack arrived exactly on time.
REQ-013 err  output  1  sticky protocol-error flag.
REQ-014 req_count  output  CNT_W  number of req pulses issued, modulo 2^CNT_W.
REQ-015 ack_count  output  CNT_W  number of on-time acks, modulo 2^CNT_W.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and GAP.
REQ-017 IDLE: start=1 or pending=1 at an edge -> REQ; otherwise remain in IDLE.
REQ-018 REQ: lasts exactly one cycle with req=1 (cycle t); req_count increments by 1 in that cycle; next state is WAIT.
REQ-019 WAIT: spans cycles t+1..t+ACK_LAT; the ack sample at t+ACK_LAT is the only valid ack; next state is GAP.
REQ-020 GAP: done=1 for exactly cycle t+ACK_LAT+1; ack_ok=1 in that cycle iff ack=1 at t+ACK_LAT; remain in GAP through cycle t+REQ_GAP-1.
REQ-021 From GAP: start or pending high -> REQ at cycle t+REQ_GAP exactly; else -> IDLE.
REQ-022 Latency from start sampled in IDLE to req high: 1 cycle.
REQ-023 Two req pulses SHALL never be fewer than REQ_GAP cycles apart.
REQ-024 req SHALL be 0 in every state except REQ.
REQ-025 start sampled while busy sets a one-deep pending bit; further starts while pending=1 are dropped; pending clears when REQ is entered.
REQ-026 An on-time ack increments ack_count in cycle t+ACK_LAT+1.
REQ-027 err SHALL set on: ack=1 in any cycle other than t+ACK_LAT (including while IDLE); ack=0 at t+ACK_LAT.
REQ-028 err SHALL remain set until clr_err=1 or reset; when clr_err and a new error coincide in one cycle, err SHALL be 1.
REQ-029 Both counters SHALL wrap from 2^CNT_W-1 to 0 with no flag and no saturation.
REQ-030 An error SHALL NOT abort the sequence; GAP timing is preserved regardless of ack behaviour.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE; req, busy, done, ack_ok and err = 0; pending = 0; both counters = 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction; an ack arriving after reset release with no preceding req SHALL set err.
REQ-033 The first req after reset release SHALL require a start sampled while rst_n=1.

Verification
REQ-034 Defaults; start pulse at cycle 0; ack=1 only at cycle 5 -> req=1 only in cycle 1; done=1 and ack_ok=1 in cycle 6; req_count=1; ack_count=1; err=0.
REQ-035 start held high, on-time acks -> req at cycles 1, 9, 17, 25; done at 6, 14, 22; err=0 throughout.
REQ-036 ack never driven after req at cycle 1 -> done=1 with ack_ok=0 at cycle 6; err=1 from cycle 6 onward; clr_err at cycle 10 -> err=0 at cycle 11.
REQ-037 ack early at cycle 4 and absent at cycle 5 -> err=1; ack_ok=0 at cycle 6; ack_count stays 0.
REQ-038 rst_n low in cycle 3 (WAIT) -> req=0, busy=0, counters=0 immediately; ack=1 after release while IDLE -> err=1.
REQ-039 CNT_W=2, five transactions with on-time acks -> req_count sequence 1,2,3,0,1; ack_count tracks it.

Source files
------------

// File: rtl/req_ack_requester.sv
// req_ack_requester: issues one-cycle req pulses and checks a fixed-latency ack.
//
// Ports:
//   clk        in   single clock, all state updates on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   request to issue one req pulse (one-deep pending while busy)
//   ack        in   acknowledge from the responder, valid only ACK_LAT cycles after req
//   clr_err    in   synchronous clear of the sticky err flag
//   req        out  one-cycle request pulse (high only in REQ)
//   busy       out  FSM not in IDLE
//   done       out  one-cycle pulse closing each transaction
//   ack_ok     out  valid with done; ack arrived exactly on time
//   err        out  sticky protocol-error flag
//   req_count  out  req pulses issued, modulo 2^CNT_W
//   ack_count  out  on-time acks, modulo 2^CNT_W
module req_ack_requester #(
    parameter int ACK_LAT = 4,
    parameter int REQ_GAP = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ack,
    input  logic             clr_err,
    output logic             req,
    output logic             busy,
    output logic             done,
    output logic             ack_ok,
    output logic             err,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] ack_count
);
    localparam int TW = $clog2(REQ_GAP + 1);
    localparam logic [TW-1:0] ACK_T   = TW'(ACK_LAT);
    localparam logic [TW-1:0] GAP_END = TW'(REQ_GAP - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             pending_q, pending_d;
    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             ack_slot;
    logic             go;

    // tmr counts cycles since the req cycle (0 in REQ), so the single valid
    // ack sample is WAIT with tmr==ACK_LAT and GAP ends at tmr==REQ_GAP-1.
    assign ack_slot = (state_q == WAIT) && (tmr_q == ACK_T);
    assign go       = start | pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            err_q     <= 1'b0;
            req_cnt_q <= '0;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            ack_ok_q  <= ack_ok_d;
            err_q     <= err_d;
            req_cnt_q <= req_cnt_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = go ? REQ : IDLE;
            REQ:  state_d = WAIT;
            WAIT: state_d = ack_slot ? GAP : WAIT;
            GAP:  state_d = (tmr_q == GAP_END) ? (go ? REQ : IDLE) : GAP;
        endcase
    end

    always_comb begin
        tmr_d     = (state_d == REQ || state_d == IDLE) ? '0 : tmr_q + 1'b1;
        // A start while busy is remembered once; entering REQ consumes it.
        pending_d = (state_d == REQ) ? 1'b0 : pending_q | (start & busy);
        done_d    = ack_slot;
        ack_ok_d  = ack_slot & ack;
        req_cnt_d = req_cnt_q + CNT_W'(state_d == REQ);
        ack_cnt_d = ack_cnt_q + CNT_W'(ack_slot & ack);
        // Error when ack disagrees with the slot: ack off-slot, or no ack on-slot.
        // A new error wins over a simultaneous clear.
        err_d     = (ack ^ ack_slot) | (err_q & ~clr_err);
    end

    always_comb begin
        req       = (state_q == REQ);
        busy      = (state_q != IDLE);
        done      = done_q;
        ack_ok    = ack_ok_q;
        err       = err_q;
        req_count = req_cnt_q;
        ack_count = ack_cnt_q;
    end
endmodule

// File: tb/tb_req_ack_requester.sv
// tb_req_ack_requester: scoreboard bench for req_ack_requester.
module tb_req_ack_requester;
    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, ack = 1'b0, clr_err = 1'b0;
    logic       req, busy, done, ack_ok, err;
    logic [7:0] req_count, ack_count;
    logic       start2 = 1'b0, ack2 = 1'b0;
    logic       req2, busy2, done2, ack_ok2, err2;
    logic [1:0] rc2, ac2;

    req_ack_requester dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .clr_err(clr_err),
        .req(req), .busy(busy), .done(done), .ack_ok(ack_ok), .err(err),
        .req_count(req_count), .ack_count(ack_count)
    );

    req_ack_requester #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .ack(ack2), .clr_err(1'b0),
        .req(req2), .busy(busy2), .done(done2), .ack_ok(ack_ok2), .err(err2),
        .req_count(rc2), .ack_count(ac2)
    );

    always #5 clk = ~clk;

    int cyc = 0, base = 0, checks = 0, errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int at; logic ok; logic [7:0] ac; logic [7:0] rc;} done_t;
    done_t dq[$];
    int    rq[$];
    done_t m_d;
    int    m_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever the DUT presents req or done.
    always @(negedge clk) begin
        if (req) begin
            if (rq.size() == 0) chk("req_unexpected_at", cyc - base, 32'hFFFF_FFFF);
            else begin
                m_r = rq.pop_front();
                chk("req_cycle", cyc - base, m_r);
            end
        end
        if (done) begin
            if (dq.size() == 0) chk("done_unexpected_at", cyc - base, 32'hFFFF_FFFF);
            else begin
                m_d = dq.pop_front();
                chk("done_cycle", cyc - base, m_d.at);
                chk("ack_ok", ack_ok, m_d.ok);
                chk("ack_count", ack_count, m_d.ac);
                chk("req_count", req_count, m_d.rc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int k);
        while (cyc - base < k) tick();
    endtask

    task automatic do_reset();
        start = 0; ack = 0; clr_err = 0; start2 = 0; ack2 = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        base = cyc;
    endtask

    task automatic drain(input string n);
        chk({n, "_req_left"}, rq.size(), 0);
        chk({n, "_done_left"}, dq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req_count", req_count, 0);
        chk("rst_ack_count", ack_count, 0);

        // Single transaction, on-time ack
        do_reset();
        rq.push_back(1);
        dq.push_back('{6, 1'b1, 8'd1, 8'd1});
        start = 1; at(1); start = 0;
        at(5); ack = 1; at(6); ack = 0;
        chk("A_err6", err, 0);
        at(10); chk("A_err10", err, 0);
        drain("A");

        // start held high, back-to-back transactions at REQ_GAP spacing
        do_reset();
        foreach (rq[i]) ;
        rq.push_back(1); rq.push_back(9); rq.push_back(17); rq.push_back(25);
        dq.push_back('{6, 1'b1, 8'd1, 8'd1});
        dq.push_back('{14, 1'b1, 8'd2, 8'd2});
        dq.push_back('{22, 1'b1, 8'd3, 8'd3});
        dq.push_back('{30, 1'b1, 8'd4, 8'd4});
        start = 1;
        at(5);  ack = 1; at(6);  ack = 0;
        at(13); ack = 1; at(14); ack = 0;
        at(21); ack = 1; at(22); ack = 0;
        at(25); start = 0;
        at(29); ack = 1; at(30); ack = 0;
        chk("B_err30", err, 0);
        at(40); chk("B_err40", err, 0);
        chk("B_busy40", busy, 0);
        drain("B");

        // Missing ack, then clear
        do_reset();
        rq.push_back(1);
        dq.push_back('{6, 1'b0, 8'd0, 8'd1});
        start = 1; at(1); start = 0;
        at(5);  chk("C_err5", err, 0);
        at(6);  chk("C_err6", err, 1);
        at(10); chk("C_err10", err, 1);
        clr_err = 1;
        at(11); clr_err = 0;
        chk("C_err11", err, 0);
        at(12); drain("C");

        // Early ack, none on time
        do_reset();
        rq.push_back(1);
        dq.push_back('{6, 1'b0, 8'd0, 8'd1});
        start = 1; at(1); start = 0;
        at(4); ack = 1; at(5); ack = 0;
        chk("D_err5", err, 1);
        at(9); chk("D_err9", err, 1);
        chk("D_ack_count", ack_count, 0);
        drain("D");

        // Pending start: two starts while busy give exactly one extra req
        do_reset();
        rq.push_back(1); rq.push_back(9);
        dq.push_back('{6, 1'b1, 8'd1, 8'd1});
        dq.push_back('{14, 1'b1, 8'd2, 8'd2});
        start = 1; at(1); start = 0;
        at(3); start = 1;
        at(5); start = 0; ack = 1;
        at(6); ack = 0;
        at(13); ack = 1; at(14); ack = 0;
        at(24); chk("P_err", err, 0);
        chk("P_req_count", req_count, 2);
        drain("P");

        // Asynchronous reset mid-transaction, then stray ack
        do_reset();
        rq.push_back(1);
        start = 1; at(1); start = 0;
        at(3);
        chk("E_busy_pre", busy, 1);
        chk("E_req_count_pre", req_count, 1);
        rst_n = 0;
        #1;
        chk("E_req", req, 0);
        chk("E_busy", busy, 0);
        chk("E_req_count", req_count, 0);
        chk("E_ack_count", ack_count, 0);
        chk("E_done", done, 0);
        at(4); rst_n = 1;
        at(5); ack = 1; at(6); ack = 0;
        chk("E_err", err, 1);
        chk("E_busy_post", busy, 0);
        at(12); drain("E");

        // Counter wrap with CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            base = cyc;
            start2 = 1; at(1); start2 = 0;
            at(5); ack2 = 1; at(6); ack2 = 0;
            chk("F_done", done2, 1);
            chk("F_ack_ok", ack_ok2, 1);
            chk("F_req_count", rc2, (i + 1) % 4);
            chk("F_ack_count", ac2, (i + 1) % 4);
            at(9);
        end
        chk("F_err", err2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
